// File: rtl/trigger_in.sv
// trigger_in: receive side of the 4-bit serial trigger link.
// Deserializes MSB-first words arriving one bit per clk40, finds word
// alignment by hunting for a periodic sync word, confirms it over
// LOCK_COUNT frames, then delivers aligned words. Drops lock after
// IDLE_TIMEOUT frames without a sync word, or on a realign pulse.
//
// Ports:
//   clk40       link bit clock, rising edge
//   rst         asynchronous active-high reset
//   trig_in     serial link bit, MSB of each word first
//   realign     synchronous pulse, forces HUNT from any state
//   dataout     last aligned word received while locked
//   data_valid  one-cycle strobe, dataout updated this cycle
//   trig_valid  data_valid for a word other than SYNC_WORD
//   locked      high while in LOCKED
//   unlock_cnt  saturating count of LOCKED -> HUNT transitions
module trigger_in #(
    parameter logic [3:0]  SYNC_WORD    = 4'b1100,
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned IDLE_TIMEOUT = 255
) (
    input  logic       clk40,
    input  logic       rst,
    input  logic       trig_in,
    input  logic       realign,
    output logic [3:0] dataout,
    output logic       data_valid,
    output logic       trig_valid,
    output logic       locked,
    output logic [7:0] unlock_cnt
);

    localparam int unsigned WORD_W = 4;
    localparam int unsigned MCNT_W = 4;
    localparam int unsigned IDLE_W = 8;
    localparam int unsigned UCNT_W = 8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WORD_W-1:0]   sr;
    logic [1:0]          ph;
    logic [MCNT_W-1:0]   match_cnt;
    logic [MCNT_W-1:0]   match_nxt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [IDLE_W-1:0]   idle_nxt;
    logic                sync_hit;
    logic                boundary;
    logic                emit;
    logic                unlock_ev;

    assign sync_hit = (sr == SYNC_WORD);
    // In HUNT the boundary is wherever the sync word appears; once aligned it is ph == 0.
    assign boundary = (state == HUNT) ? sync_hit : (ph == 2'd0);

    // State register
    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counter updates and strobes
    always_comb begin
        state_nxt = state;
        match_nxt = match_cnt;
        idle_nxt  = idle_cnt;
        emit      = 1'b0;
        unlock_ev = 1'b0;

        unique case (state)
            HUNT: begin
                match_nxt = '0;
                idle_nxt  = '0;
                if (sync_hit) begin
                    match_nxt = MCNT_W'(1);
                    state_nxt = (LOCK_COUNT == 32'd1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                if (boundary) begin
                    if (sync_hit) begin
                        match_nxt = match_cnt + MCNT_W'(1);
                        if (match_nxt == MCNT_W'(LOCK_COUNT)) begin
                            state_nxt = LOCKED;
                        end
                    end else begin
                        match_nxt = '0;
                        state_nxt = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    emit = 1'b1;
                    if (sync_hit) begin
                        idle_nxt = '0;
                    end else begin
                        idle_nxt = idle_cnt + IDLE_W'(1);
                        if (idle_nxt == IDLE_W'(IDLE_TIMEOUT)) begin
                            state_nxt = HUNT;
                            unlock_ev = 1'b1;
                            idle_nxt  = '0;
                            match_nxt = '0;
                        end
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
                match_nxt = '0;
                idle_nxt  = '0;
            end
        endcase

        // realign overrides any lock or timeout decided above
        if (realign) begin
            state_nxt = HUNT;
            match_nxt = '0;
            idle_nxt  = '0;
            unlock_ev = (state == LOCKED);
        end
    end

    // Shift register, phase counter, counters and registered outputs
    always_ff @(posedge clk40 or posedge rst) begin
        if (rst) begin
            sr         <= '0;
            ph         <= '0;
            match_cnt  <= '0;
            idle_cnt   <= '0;
            dataout    <= '0;
            data_valid <= 1'b0;
            trig_valid <= 1'b0;
            locked     <= 1'b0;
            unlock_cnt <= '0;
        end else begin
            sr        <= {sr[WORD_W-2:0], trig_in};
            match_cnt <= match_nxt;
            idle_cnt  <= idle_nxt;

            // Sync seen in HUNT is the last cycle of a word, so the next cycle is phase 1.
            if (state == HUNT) begin
                if (sync_hit) begin
                    ph <= 2'd1;
                end
            end else begin
                ph <= ph + 2'd1;
            end

            data_valid <= emit;
            trig_valid <= emit && !sync_hit;
            if (emit) begin
                dataout <= sr;
            end

            locked <= (state_nxt == LOCKED);

            if (unlock_ev && (unlock_cnt != {UCNT_W{1'b1}})) begin
                unlock_cnt <= unlock_cnt + UCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_trigger_in.sv
// Testbench for trigger_in: a word-level transmitter feeds the serial link
// (sync fill when idle), pushing the expected (word, trig_valid) pair into a
// scoreboard for every word sent while scoring is enabled; an independent
// monitor pops and compares on each data_valid strobe.
module tb_trigger_in;

    localparam logic [3:0] SYNC = 4'b1100;

    typedef struct packed {
        logic [3:0] w;
        logic [2:0] n;
        logic       mark;
    } tx_t;

    typedef struct packed {
        logic [3:0] w;
        logic       t;
    } exp_t;

    logic       clk40;
    logic       rst;
    logic       trig_in;
    logic       realign;
    logic [3:0] dataout;
    logic       data_valid;
    logic       trig_valid;
    logic       locked;
    logic [7:0] unlock_cnt;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   mark_cyc = -1;
    int   mark_seq = 0;
    int   lock_cyc = 0;
    int   last_dv_cyc = 0;
    bit   gap_armed = 1'b0;
    bit   fill_en = 1'b0;
    bit   sb_on = 1'b0;
    tx_t  wordq[$];
    exp_t exp_q[$];

    trigger_in #(
        .SYNC_WORD   (SYNC),
        .LOCK_COUNT  (4),
        .IDLE_TIMEOUT(3)
    ) dut (
        .clk40     (clk40),
        .rst       (rst),
        .trig_in   (trig_in),
        .realign   (realign),
        .dataout   (dataout),
        .data_valid(data_valid),
        .trig_valid(trig_valid),
        .locked    (locked),
        .unlock_cnt(unlock_cnt)
    );

    initial begin
        clk40 = 1'b0;
        forever #5 clk40 = ~clk40;
    end

    always @(posedge clk40) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic q_word(input logic [3:0] w, input logic mk);
        tx_t e;
        e.w = w; e.n = 3'd4; e.mark = mk;
        wordq.push_back(e);
    endtask

    task automatic q_zero(input int k);
        tx_t e;
        e.w = 4'd0; e.n = 3'd1; e.mark = 1'b0;
        for (int i = 0; i < k; i++) wordq.push_back(e);
    endtask

    // Transmitter: queued entries first, otherwise sync fill, otherwise zeros.
    initial begin
        tx_t  ent;
        exp_t ex;
        trig_in = 1'b0;
        forever begin
            @(negedge clk40);
            if (rst) begin
                trig_in = 1'b0;
            end else if (wordq.size() != 0 || fill_en) begin
                if (wordq.size() != 0) ent = wordq.pop_front();
                else begin ent.w = SYNC; ent.n = 3'd4; ent.mark = 1'b0; end
                for (int i = int'(ent.n) - 1; i >= 0; i--) begin
                    if (i != int'(ent.n) - 1) @(negedge clk40);
                    trig_in = ent.w[i];
                end
                if (ent.n == 3'd4) begin
                    if (ent.mark) begin mark_cyc = cyc; mark_seq++; end
                    if (sb_on) begin
                        ex.w = ent.w; ex.t = (ent.w != SYNC);
                        exp_q.push_back(ex);
                    end
                end
            end else begin
                trig_in = 1'b0;
            end
        end
    end

    // Monitor: scoreboard compare on every strobe, strobe spacing while locked.
    always @(negedge clk40) begin
        exp_t e;
        if (rst) begin
            gap_armed = 1'b0;
        end else if (data_valid) begin
            if (gap_armed) chk("dv_spacing", cyc - last_dv_cyc, 4);
            gap_armed   = 1'b1;
            last_dv_cyc = cyc;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_word_trig", int'({dataout, trig_valid}), int'({e.w, e.t}));
            end
        end else begin
            chk("trig_only_with_dv", int'(trig_valid), 0);
            if (!locked) gap_armed = 1'b0;
        end
    end

    // Waits for the marked sync word to be sent, then for locked; lock must
    // rise 14 posedges after the negedge that drove its last bit.
    task automatic check_lock_at(input string name, input int seq0);
        int n = 0;
        while (mark_seq == seq0 && n < 64) begin @(negedge clk40); n++; end
        while (!locked && n < 128) begin @(negedge clk40); n++; end
        if (mark_seq == seq0 || !locked) chk({name, "_timeout"}, 0, 1);
        else chk(name, cyc - mark_cyc, 14);
        lock_cyc = cyc;
    endtask

    task automatic wait_locked(input string name);
        int n = 0;
        while (!locked && n < 40) begin @(negedge clk40); n++; end
        if (!locked) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int seq0;
        int n;
        rst = 1'b1;
        realign = 1'b0;
        repeat (3) @(negedge clk40);
        chk("reset_outputs", int'({dataout, data_valid, trig_valid, locked, unlock_cnt}), 0);

        // Lock from reset at a 2-bit phase offset
        rst = 1'b0;
        seq0 = mark_seq;
        q_zero(2);
        q_word(SYNC, 1'b1);
        fill_en = 1'b1;
        check_lock_at("lock_from_reset", seq0);
        n = 0;
        while (!data_valid && n < 10) begin @(negedge clk40); n++; end
        chk("first_dv_delay", data_valid ? cyc - lock_cyc : -1, 4);
        sb_on = 1'b1;
        repeat (16) @(negedge clk40);

        // Data words after lock
        q_word(4'b0001, 1'b0);
        q_word(4'b1010, 1'b0);
        q_word(4'b1100, 1'b0);
        q_word(4'b1111, 1'b0);
        repeat (28) @(negedge clk40);

        // Two non-sync frames then sync: lock holds
        q_word(4'b0001, 1'b0);
        q_word(4'b0001, 1'b0);
        q_word(SYNC, 1'b0);
        repeat (28) @(negedge clk40);
        chk("idle_hold_locked", int'(locked), 1);
        sb_on = 1'b0;
        repeat (8) @(negedge clk40);
        chk("sb_drained", exp_q.size(), 0);

        // Three non-sync frames: lock drops right after the third
        seq0 = mark_seq;
        q_word(4'b0001, 1'b0);
        q_word(4'b0001, 1'b0);
        q_word(4'b0001, 1'b1);
        n = 0;
        while (locked && n < 40) begin @(negedge clk40); n++; end
        chk("timeout_fall_cycle", (mark_seq != seq0) ? cyc - mark_cyc : -1, 2);
        chk("unlock_after_timeout", int'(unlock_cnt), 1);

        // Realign while LOCKED, held into a HUNT cycle
        wait_locked("relock_after_timeout");
        realign = 1'b1;
        @(negedge clk40);
        chk("realign_locked_drop", int'(locked), 0);
        chk("realign_locked_count", int'(unlock_cnt), 2);
        fill_en = 1'b0;
        @(negedge clk40);
        realign = 1'b0;
        chk("realign_hunt_count", int'(unlock_cnt), 2);
        repeat (20) @(negedge clk40);
        chk("idle_link_unlocked", int'(locked), 0);

        // Realign in the cycle VERIFY would lock
        seq0 = mark_seq;
        q_word(SYNC, 1'b1);
        q_word(SYNC, 1'b0);
        q_word(SYNC, 1'b0);
        q_word(SYNC, 1'b0);
        n = 0;
        while (mark_seq == seq0 && n < 64) begin @(negedge clk40); n++; end
        while (cyc != mark_cyc + 13 && n < 128) begin @(negedge clk40); n++; end
        realign = 1'b1;
        @(negedge clk40);
        realign = 1'b0;
        chk("realign_at_lock_locked", int'(locked), 0);
        chk("realign_at_lock_count", int'(unlock_cnt), 2);
        repeat (8) @(negedge clk40);

        // Broken verify: sync, sync, 0101, then a full re-verify from the next sync
        seq0 = mark_seq;
        q_word(SYNC, 1'b0);
        q_word(SYNC, 1'b0);
        q_word(4'b0101, 1'b0);
        q_word(SYNC, 1'b1);
        fill_en = 1'b1;
        check_lock_at("broken_verify_relock", seq0);

        // Reset asserted mid-lock on a strobe cycle
        n = 0;
        while (!data_valid && n < 8) begin @(negedge clk40); n++; end
        chk("pre_reset_dataout", int'(dataout), int'(SYNC));
        #1 rst = 1'b1;
        fill_en = 1'b0;
        #1 chk("reset_midlock_outputs", int'({dataout, data_valid, trig_valid, locked, unlock_cnt}), 0);
        repeat (6) @(negedge clk40);
        rst = 1'b0;
        seq0 = mark_seq;
        q_zero(1);
        q_word(SYNC, 1'b1);
        fill_en = 1'b1;
        check_lock_at("relock_after_reset", seq0);

        // Saturation of unlock_cnt
        for (int i = 0; i < 260; i++) begin
            wait_locked("sat_relock");
            realign = 1'b1;
            @(negedge clk40);
            realign = 1'b0;
            if (i == 0 || i == 253 || i == 254 || i == 259)
                chk("unlock_sat", int'(unlock_cnt), (i + 1 > 255) ? 255 : i + 1);
        end
        repeat (4) @(negedge clk40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
